// File: rtl/bram_acc_engine.sv
// Multi-lane streaming accumulator: reads rows from BRAM0, sums each lane, writes results to BRAM1.
// Optional per-lane saturation and sticky sat_o flag when BRAM_ACC_SAT_EN is defined.
module bram_acc_engine #(
    parameter int LANES  = 4,
    parameter int IN_W   = 8,
    parameter int ACC_W  = 16,
    parameter int AWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_run_i,
    input  logic [AWIDTH:0]          run_count_i,
    input  logic [AWIDTH-1:0]        src_base_i,
    input  logic [AWIDTH-1:0]        dst_base_i,
    input  logic                     mode_i,
    input  logic [LANES*IN_W-1:0]    q_b0_i,
    output logic                     idle_o,
    output logic                     read_o,
    output logic                     write_o,
    output logic                     done_o,
    output logic [AWIDTH-1:0]        addr_b0_o,
    output logic                     ce_b0_o,
    output logic                     we_b0_o,
    output logic [LANES*IN_W-1:0]    d_b0_o,
    output logic [AWIDTH-1:0]        addr_b1_o,
    output logic                     ce_b1_o,
    output logic                     we_b1_o,
    output logic [LANES*ACC_W-1:0]   d_b1_o
`ifdef BRAM_ACC_SAT_EN
    ,
    output logic                     sat_o
`endif
);

    localparam int DW0 = LANES * IN_W;
    localparam int SW  = ACC_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [AWIDTH:0]   count_reg;
    logic [AWIDTH:0]   k_reg;
    logic [AWIDTH-1:0] src_base_reg;
    logic [AWIDTH-1:0] dst_base_reg;
    logic              mode_reg;
    logic              rd_valid_reg;
    logic              rd_last_reg;
    logic [AWIDTH-1:0] rd_row_reg;
    logic              wr_valid_reg;
    logic [AWIDTH-1:0] wr_addr_reg;

    logic start_run;
    logic issue_last;

    assign start_run  = (state_reg == ST_IDLE) && start_run_i && (run_count_i != '0);
    assign issue_last = (state_reg == ST_RUN) && (k_reg == count_reg - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_run_i) begin
                    state_next = (run_count_i != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (issue_last) begin
                    state_next = ST_FLUSH;
                end
            end
            // Leave once the last row's data has been consumed; its write
            // happens this cycle or already happened.
            ST_FLUSH: begin
                if (!rd_valid_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        idle_o    = 1'b0;
        read_o    = 1'b0;
        ce_b0_o   = 1'b0;
        done_o    = 1'b0;
        addr_b0_o = '0;
        case (state_reg)
            ST_IDLE: idle_o = 1'b1;
            ST_RUN: begin
                read_o    = 1'b1;
                ce_b0_o   = 1'b1;
                addr_b0_o = src_base_reg + k_reg[AWIDTH-1:0];
            end
            ST_DONE: done_o = 1'b1;
            default: begin
                idle_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg    <= '0;
            k_reg        <= '0;
            src_base_reg <= '0;
            dst_base_reg <= '0;
            mode_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
            rd_row_reg   <= '0;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= '0;
        end else begin
            if (start_run) begin
                count_reg    <= run_count_i;
                src_base_reg <= src_base_i;
                dst_base_reg <= dst_base_i;
                mode_reg     <= mode_i;
                k_reg        <= '0;
            end else if (state_reg == ST_RUN) begin
                k_reg <= k_reg + 1'b1;
            end
            rd_valid_reg <= (state_reg == ST_RUN);
            rd_last_reg  <= issue_last;
            rd_row_reg   <= k_reg[AWIDTH-1:0];
            // Total-only mode writes just once, in the slot of the last row.
            wr_valid_reg <= rd_valid_reg && (!mode_reg || rd_last_reg);
            wr_addr_reg  <= mode_reg ? dst_base_reg : dst_base_reg + rd_row_reg;
        end
    end

`ifdef BRAM_ACC_SAT_EN
    logic [LANES-1:0] lane_sat;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ACC_W-1:0] acc_reg;
            logic [ACC_W-1:0] acc_next;
`ifdef BRAM_ACC_SAT_EN
            logic [ACC_W:0] sum;
            assign sum           = {1'b0, acc_reg} + SW'(q_b0_i[IN_W*gi +: IN_W]);
            assign lane_sat[gi]  = sum[ACC_W];
            assign acc_next      = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            logic [ACC_W-1:0] sum;
            assign sum      = acc_reg + ACC_W'(q_b0_i[IN_W*gi +: IN_W]);
            assign acc_next = sum;
`endif
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    acc_reg <= '0;
                end else if (start_run) begin
                    acc_reg <= '0;
                end else if (rd_valid_reg) begin
                    acc_reg <= acc_next;
                end
            end

            assign d_b1_o[ACC_W*gi +: ACC_W] = wr_valid_reg ? acc_reg : '0;
        end
    endgenerate

`ifdef BRAM_ACC_SAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_o <= 1'b0;
        end else if ((state_reg == ST_IDLE) && start_run_i) begin
            sat_o <= 1'b0;
        end else if (rd_valid_reg && (|lane_sat)) begin
            sat_o <= 1'b1;
        end
    end
`endif

    assign we_b0_o   = 1'b0;
    assign d_b0_o    = {DW0{1'b0}};
    assign ce_b1_o   = wr_valid_reg;
    assign we_b1_o   = wr_valid_reg;
    assign write_o   = wr_valid_reg;
    assign addr_b1_o = wr_valid_reg ? wr_addr_reg : '0;

endmodule

// File: tb/tb_bram_acc_engine.sv
// Scoreboard bench for bram_acc_engine: BRAM models, expected reads/writes queued per run.
`timescale 1ns/1ps
module tb_bram_acc_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [8:0]  run_count;
    logic [7:0]  src_base, dst_base;
    logic        mode;
    logic [31:0] q_b0;
    logic        idle_o, read_o, write_o, done_o, ce_b0, we_b0, ce_b1, we_b1;
    logic [7:0]  addr_b0, addr_b1;
    logic [31:0] d_b0;
    logic [63:0] d_b1;
    logic        sat_main;

    // Second instance, 8-bit accumulators, for overflow behaviour
    logic        s_start;
    logic [4:0]  s_count;
    logic [7:0]  s_q;
    logic        s_idle, s_read, s_write, s_done, s_ce_b0, s_we_b0, s_ce_b1, s_we_b1;
    logic [3:0]  s_addr_b0, s_addr_b1;
    logic [7:0]  s_d_b0, s_d_b1;
    logic        s_sat;

    logic [31:0] mem0 [256];
    logic [7:0]  mem_s [16];

    int check_count = 0;
    int pass_count  = 0;
    logic [63:0] last_wr_data;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    logic [7:0] rd_q [$];
    wr_t        wr_q [$];

    always #5 clk = ~clk;

    bram_acc_engine dut (
        .clk(clk), .reset_n(reset_n), .start_run_i(start), .run_count_i(run_count),
        .src_base_i(src_base), .dst_base_i(dst_base), .mode_i(mode), .q_b0_i(q_b0),
        .idle_o(idle_o), .read_o(read_o), .write_o(write_o), .done_o(done_o),
        .addr_b0_o(addr_b0), .ce_b0_o(ce_b0), .we_b0_o(we_b0), .d_b0_o(d_b0),
        .addr_b1_o(addr_b1), .ce_b1_o(ce_b1), .we_b1_o(we_b1), .d_b1_o(d_b1)
`ifdef BRAM_ACC_SAT_EN
        , .sat_o(sat_main)
`endif
    );

    bram_acc_engine #(.LANES(1), .IN_W(8), .ACC_W(8), .AWIDTH(4)) u_sat (
        .clk(clk), .reset_n(reset_n), .start_run_i(s_start), .run_count_i(s_count),
        .src_base_i(4'h0), .dst_base_i(4'h3), .mode_i(1'b1), .q_b0_i(s_q),
        .idle_o(s_idle), .read_o(s_read), .write_o(s_write), .done_o(s_done),
        .addr_b0_o(s_addr_b0), .ce_b0_o(s_ce_b0), .we_b0_o(s_we_b0), .d_b0_o(s_d_b0),
        .addr_b1_o(s_addr_b1), .ce_b1_o(s_ce_b1), .we_b1_o(s_we_b1), .d_b1_o(s_d_b1)
`ifdef BRAM_ACC_SAT_EN
        , .sat_o(s_sat)
`endif
    );

`ifndef BRAM_ACC_SAT_EN
    assign sat_main = 1'b0;
    assign s_sat    = 1'b0;
`endif

    // Registered-read BRAM models, one cycle latency
    always @(posedge clk) begin
        if (ce_b0) q_b0 <= mem0[addr_b0];
        if (s_ce_b0) s_q <= mem_s[s_addr_b0];
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input int n, input logic [7:0] sb, input logic [7:0] db,
                          input logic md, input bit perturb);
        logic [15:0] acc [4];
        logic [31:0] row;
        logic [63:0] word;
        logic [7:0]  ra;
        wr_t         w;
        wr_t         got;
        int          rd_idx;
        int          done_cyc;
        int          exp_done;
        rd_q.delete();
        wr_q.delete();
        for (int i = 0; i < 4; i++) acc[i] = '0;
        for (int k = 0; k < n; k++) begin
            ra = sb + 8'(k);
            row = mem0[ra];
            rd_q.push_back(ra);
            for (int i = 0; i < 4; i++) acc[i] = acc[i] + {8'h00, row[8*i +: 8]};
            word = {acc[3], acc[2], acc[1], acc[0]};
            if (!md || k == n - 1) begin
                w.addr = md ? db : db + 8'(k);
                w.data = word;
                w.cyc  = k + 3;
                wr_q.push_back(w);
            end
        end
        exp_done = (n == 0) ? 1 : n + 3;

        @(negedge clk);
        start = 1'b1; run_count = 9'(n); src_base = sb; dst_base = db; mode = md;
        @(negedge clk);
        start = 1'b0;
        rd_idx = 0;
        done_cyc = -1;
        for (int c = 1; c <= n + 8; c++) begin
            if (c == 1 && n != 0) check_val("idle_busy", idle_o, 0);
            if (ce_b0) begin
                if (rd_q.size() == 0) begin
                    check_val("rd_extra", 1, 0);
                end else begin
                    check_val("rd_addr", addr_b0, rd_q.pop_front());
                    check_val("rd_cyc", c, rd_idx + 1);
                    rd_idx++;
                end
            end
            if (ce_b1) begin
                check_val("wr_strobes", {we_b1, write_o}, 2'b11);
                if (wr_q.size() == 0) begin
                    check_val("wr_extra", 1, 0);
                end else begin
                    got = wr_q.pop_front();
                    check_val("wr_addr", addr_b1, got.addr);
                    check_val("wr_data", d_b1, got.data);
                    check_val("wr_cyc", c, got.cyc);
                    last_wr_data = d_b1;
                end
            end else begin
                check_val("idle_wr_zero", {addr_b1, d_b1}, '0);
            end
            if (done_o) begin
                check_val("done_cyc", c, exp_done);
                done_cyc = c;
                break;
            end
            if (perturb && c == 2) begin
                start = 1'b1; run_count = 9'd5; src_base = ~sb; dst_base = ~db; mode = ~md;
            end
            if (perturb && c == 3) start = 1'b0;
            @(negedge clk);
        end
        if (done_cyc < 0) check_val("done_timeout", 0, 1);
        @(negedge clk);
        check_val("idle_after", idle_o, 1);
        check_val("rd_left", rd_q.size(), 0);
        check_val("wr_left", wr_q.size(), 0);
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0; start = 1'b0; run_count = '0; src_base = '0; dst_base = '0; mode = 1'b0;
        s_start = 1'b0; s_count = '0;
        for (int a = 0; a < 256; a++) mem0[a] = $urandom;
        for (int a = 0; a < 16; a++) mem_s[a] = '0;
        mem0[8'h10] = 32'h04030201;
        mem0[8'h11] = 32'h10101010;
        mem0[8'h12] = 32'h020100FF;
        mem_s[0] = 8'hF0;
        mem_s[1] = 8'h20;
        last_wr_data = '0;

        repeat (3) @(negedge clk);
        check_val("rst_idle", idle_o, 1);
        check_val("rst_strobes", {read_o, write_o, done_o, ce_b0, we_b0, ce_b1, we_b1}, '0);
        check_val("rst_addr", {addr_b0, addr_b1}, '0);
        check_val("rst_data", {d_b1, d_b0}, '0);
        check_val("rst_sat", sat_main, 0);
        reset_n = 1'b1;

        do_run(3, 8'h10, 8'h20, 1'b0, 1'b0);
        check_val("plan_m0_last", last_wr_data, {16'd22, 16'd20, 16'd18, 16'd272});
        last_wr_data = '0;
        do_run(3, 8'h10, 8'h20, 1'b1, 1'b0);
        check_val("plan_m1_total", last_wr_data, {16'd22, 16'd20, 16'd18, 16'd272});
        do_run(0, 8'h10, 8'h20, 1'b0, 1'b0);
        do_run(4, 8'hFE, 8'hFF, 1'b0, 1'b0);
        do_run(3, 8'h10, 8'h20, 1'b0, 1'b1);
        do_run(256, 8'h80, 8'h40, 1'b1, 1'b0);

        // Abort a run with reset, then check a fresh run
        @(negedge clk);
        start = 1'b1; run_count = 9'd8; src_base = 8'h00; dst_base = 8'h00; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("abort_idle", idle_o, 1);
        check_val("abort_strobes", {read_o, write_o, done_o, ce_b0, ce_b1, we_b1}, '0);
        check_val("abort_addr", {addr_b0, addr_b1}, '0);
        check_val("abort_data", d_b1, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("abort_quiet", {ce_b0, ce_b1, done_o}, '0);
        end
        reset_n = 1'b1;
        do_run(1, 8'h30, 8'h50, 1'b0, 1'b0);

        // Overflow on an 8-bit accumulator: F0 + 20
        @(negedge clk);
        s_start = 1'b1; s_count = 5'd2;
        @(negedge clk);
        s_start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (s_ce_b1) begin
                seen = 1'b1;
                check_val("sat_wr_cyc", c, 4);
                check_val("sat_wr_addr", s_addr_b1, 4'h3);
`ifdef BRAM_ACC_SAT_EN
                check_val("sat_wr_data", s_d_b1, 8'hFF);
`else
                check_val("wrap_wr_data", s_d_b1, 8'h10);
`endif
            end
            @(negedge clk);
        end
        check_val("sat_wr_seen", seen, 1);
`ifdef BRAM_ACC_SAT_EN
        check_val("sat_flag", s_sat, 1);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
